// File: rtl/corr_pkg.sv
// Shared definitions for the correlator event FIFO: register map, CTRL bits,
// queued event layout and the magnitude helper.
package corr_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_THR_LO   = 8'h08;
  localparam logic [7:0] OFF_THR_HI   = 8'h0C;
  localparam logic [7:0] OFF_HEAD_CNT = 8'h10;
  localparam logic [7:0] OFF_HEAD_LO  = 8'h14;
  localparam logic [7:0] OFF_HEAD_HI  = 8'h18;
  localparam logic [7:0] OFF_PEAK_LO  = 8'h1C;
  localparam logic [7:0] OFF_PEAK_HI  = 8'h20;
  localparam logic [7:0] OFF_PEAK_CNT = 8'h24;
  localparam logic [7:0] OFF_DROPS    = 8'h28;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  typedef struct packed {
    logic [31:0] cnt;
    logic [63:0] sum;
  } corr_event_t;

  // -2^63 wraps back to 2^63, which is exactly the unsigned magnitude we want.
  function automatic logic [63:0] abs64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and synchronous flush.
// Pop on empty is ignored; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/corr_event_fifo.sv
// Correlator dump qualifier: 3-stage magnitude/threshold pipeline feeding an
// event FIFO, with peak tracking, drop counting and a bus register window.
module corr_event_fifo
  import corr_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'hFE000800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] Wdata,
  input  logic        write,
  input  logic        read,
  output logic [31:0] Rdata,
  input  logic        CorrValid,
  input  logic [31:0] CorrLow,
  input  logic [31:0] CorrHigh,
  input  logic [31:0] CorrCnt,
  output logic        Irq
);

  localparam int LW = $clog2(DEPTH+1);

  logic        r_enable, r_irq_en, r_irq, r_ovf;
  logic [31:0] r_thr_lo, r_thr_hi, r_drops, r_peak_cnt;
  logic [63:0] r_peak;

  logic        r_s1_valid, r_s2_valid;
  logic [31:0] r_s1_cnt, r_s2_cnt;
  logic [63:0] r_s1_sum, r_s2_sum, r_s2_mag;

  logic [31:0]   w_off;
  logic [7:0]    w_off8;
  logic          w_in_win, w_wr, w_rd, w_clear, w_pop;
  logic          w_qual, w_push, w_drop;
  logic          w_full, w_empty;
  logic [LW-1:0] w_level;
  logic [31:0]   w_level32;
  corr_event_t   w_head, w_new;
  logic [31:0]   w_rdata;

  assign w_off    = addr - BASE;
  assign w_off8   = w_off[7:0];
  assign w_in_win = (w_off[31:8] == '0) && (w_off[1:0] == 2'b00);
  assign w_wr     = write & w_in_win;
  assign w_rd     = read & w_in_win;
  assign w_clear  = w_wr & (w_off8 == OFF_CTRL) & Wdata[CTRL_CLEAR];
  assign w_pop    = w_rd & (w_off8 == OFF_HEAD_HI);

  assign w_qual = r_s2_valid & (r_s2_mag >= {r_thr_hi, r_thr_lo});
  assign w_push = w_qual & ~w_clear;
  // A pop frees a slot in the same cycle, so only an unaccompanied full push drops.
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_new  = '{cnt: r_s2_cnt, sum: r_s2_sum};

  sync_fifo #(.WIDTH($bits(corr_event_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_flush (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_new),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_thr_lo <= '0;
      r_thr_hi <= '0;
    end else if (w_wr) begin
      case (w_off8)
        OFF_CTRL: begin
          r_enable <= Wdata[CTRL_ENABLE];
          r_irq_en <= Wdata[CTRL_IRQ_EN];
        end
        OFF_THR_LO: r_thr_lo <= Wdata;
        OFF_THR_HI: r_thr_hi <= Wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_s1_sum   <= '0;
      r_s2_cnt   <= '0;
      r_s2_sum   <= '0;
      r_s2_mag   <= '0;
    end else begin
      r_s1_valid <= CorrValid & r_enable & ~w_clear;
      r_s2_valid <= r_s1_valid & ~w_clear;
      r_s1_cnt   <= CorrCnt;
      r_s1_sum   <= {CorrHigh, CorrLow};
      r_s2_cnt   <= r_s1_cnt;
      r_s2_sum   <= r_s1_sum;
      r_s2_mag   <= abs64(r_s1_sum);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak     <= '0;
      r_peak_cnt <= '0;
      r_drops    <= '0;
      r_ovf      <= 1'b0;
    end else if (w_clear) begin
      r_peak     <= '0;
      r_peak_cnt <= '0;
      r_drops    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_s2_valid && (r_s2_mag > r_peak)) begin
        r_peak     <= r_s2_mag;
        r_peak_cnt <= r_s2_cnt;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drops != '1) r_drops <= r_drops + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= r_irq_en & ~w_empty;
  end

  assign Irq       = r_irq;
  assign w_level32 = 32'(w_level);

  always_comb begin
    w_rdata = '0;
    if (rst && w_rd) begin
      case (w_off8)
        OFF_CTRL:     w_rdata = {30'd0, r_irq_en, r_enable};
        OFF_STATUS:   w_rdata = {20'd0, r_ovf, w_full, w_empty, w_level32[8:0]};
        OFF_THR_LO:   w_rdata = r_thr_lo;
        OFF_THR_HI:   w_rdata = r_thr_hi;
        OFF_HEAD_CNT: w_rdata = w_head.cnt;
        OFF_HEAD_LO:  w_rdata = w_head.sum[31:0];
        OFF_HEAD_HI:  w_rdata = w_head.sum[63:32];
        OFF_PEAK_LO:  w_rdata = r_peak[31:0];
        OFF_PEAK_HI:  w_rdata = r_peak[63:32];
        OFF_PEAK_CNT: w_rdata = r_peak_cnt;
        OFF_DROPS:    w_rdata = r_drops;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign Rdata = w_rdata;

endmodule

// File: tb/tb_corr_event_fifo.sv
// Directed bench for corr_event_fifo: a vector table for register-level
// sequences plus hand-timed sequences for overflow, full push+pop, reset and clear.
module tb_corr_event_fifo;

  localparam logic [31:0] BASE = 32'hFE000800;

  localparam logic [7:0] CTRL = 8'h00, STATUS = 8'h04, THR_LO = 8'h08, THR_HI = 8'h0C;
  localparam logic [7:0] HEAD_CNT = 8'h10, HEAD_LO = 8'h14, HEAD_HI = 8'h18;
  localparam logic [7:0] PEAK_LO = 8'h1C, PEAK_HI = 8'h20, PEAK_CNT = 8'h24, DROPS = 8'h28;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = '0, Wdata = '0, Rdata;
  logic        write = 1'b0, read = 1'b0;
  logic        CorrValid = 1'b0;
  logic [31:0] CorrLow = '0, CorrHigh = '0, CorrCnt = '0;
  logic        Irq;

  int n_checks = 0;
  int n_errors = 0;

  corr_event_fifo #(.DEPTH(16), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
    .Rdata(Rdata), .CorrValid(CorrValid), .CorrLow(CorrLow), .CorrHigh(CorrHigh),
    .CorrCnt(CorrCnt), .Irq(Irq)
  );

  always #5 clk = ~clk;

  typedef enum int {K_WR, K_RD, K_DUMP, K_IDLE, K_IRQ} kind_t;
  typedef struct {
    kind_t       kind;
    string       name;
    logic [7:0]  off;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    addr = BASE + {24'd0, off}; Wdata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] off, input logic [31:0] exp);
    @(negedge clk);
    addr = BASE + {24'd0, off}; read = 1'b1;
    #1 chk(nm, Rdata, exp);
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic dump(input logic [31:0] lo, input logic [31:0] hi, input logic [31:0] cnt);
    @(negedge clk);
    CorrLow = lo; CorrHigh = hi; CorrCnt = cnt; CorrValid = 1'b1;
    @(posedge clk); #1;
    CorrValid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic irq_chk(input string nm, input logic exp);
    @(negedge clk);
    chk(nm, {31'd0, Irq}, {31'd0, exp});
  endtask

  task automatic add(input kind_t k, input string nm, input logic [7:0] off,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [31:0] exp);
    vec_t v;
    v.kind = k; v.name = nm; v.off = off; v.a = a; v.b = b; v.c = c; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, RO write, unmapped read, disabled capture.
    add(K_RD,  "rst_status",    STATUS,   0, 0, 0, 32'h200);
    add(K_RD,  "rst_ctrl",      CTRL,     0, 0, 0, 32'h0);
    add(K_RD,  "rst_head_hi",   HEAD_HI,  0, 0, 0, 32'h0);
    add(K_IRQ, "rst_irq",       0,        0, 0, 0, 32'h0);
    add(K_WR,  "",              STATUS,   32'hFFFF_FFFF, 0, 0, 0);
    add(K_RD,  "ro_write",      STATUS,   0, 0, 0, 32'h200);
    add(K_RD,  "unmapped",      8'h2C,    0, 0, 0, 32'h0);
    add(K_WR,  "",              CTRL,     32'h2, 0, 0, 0);
    add(K_DUMP,"",              0,        32'h5, 32'h0, 32'd1, 0);
    add(K_IDLE,"",              0,        32'd4, 0, 0, 0);
    add(K_RD,  "dis_status",    STATUS,   0, 0, 0, 32'h200);
    add(K_RD,  "dis_peak",      PEAK_LO,  0, 0, 0, 32'h0);
    // Threshold qualification, equality included.
    add(K_WR,  "",              THR_LO,   32'h100, 0, 0, 0);
    add(K_WR,  "",              THR_HI,   32'h0, 0, 0, 0);
    add(K_WR,  "",              CTRL,     32'h3, 0, 0, 0);
    add(K_RD,  "thr_readback",  THR_LO,   0, 0, 0, 32'h100);
    add(K_DUMP,"",              0,        32'hFFFF_FF00, 32'hFFFF_FFFF, 32'd5, 0);
    add(K_DUMP,"",              0,        32'h0000_00FF, 32'h0, 32'd6, 0);
    add(K_DUMP,"",              0,        32'h0000_0101, 32'h0, 32'd7, 0);
    add(K_IDLE,"",              0,        32'd4, 0, 0, 0);
    add(K_RD,  "thr_status",    STATUS,   0, 0, 0, 32'h002);
    add(K_IRQ, "thr_irq",       0,        0, 0, 0, 32'h1);
    add(K_RD,  "thr_peak_lo",   PEAK_LO,  0, 0, 0, 32'h101);
    add(K_RD,  "thr_peak_hi",   PEAK_HI,  0, 0, 0, 32'h0);
    add(K_RD,  "thr_peak_cnt",  PEAK_CNT, 0, 0, 0, 32'd7);
    add(K_RD,  "thr_h0_cnt",    HEAD_CNT, 0, 0, 0, 32'd5);
    add(K_RD,  "thr_h0_lo",     HEAD_LO,  0, 0, 0, 32'hFFFF_FF00);
    add(K_RD,  "thr_h0_hi",     HEAD_HI,  0, 0, 0, 32'hFFFF_FFFF);
    add(K_RD,  "thr_h1_cnt",    HEAD_CNT, 0, 0, 0, 32'd7);
    add(K_RD,  "thr_h1_lo",     HEAD_LO,  0, 0, 0, 32'h101);
    add(K_RD,  "thr_h1_hi",     HEAD_HI,  0, 0, 0, 32'h0);
    add(K_RD,  "thr_empty",     STATUS,   0, 0, 0, 32'h200);
    add(K_RD,  "pop_empty",     HEAD_HI,  0, 0, 0, 32'h0);
    add(K_RD,  "pop_empty_st",  STATUS,   0, 0, 0, 32'h200);
    add(K_IRQ, "thr_irq_off",   0,        0, 0, 0, 32'h0);
    // Most negative sum against an all-ones threshold.
    add(K_WR,  "",              CTRL,     32'h5, 0, 0, 0);
    add(K_WR,  "",              THR_LO,   32'hFFFF_FFFF, 0, 0, 0);
    add(K_WR,  "",              THR_HI,   32'hFFFF_FFFF, 0, 0, 0);
    add(K_DUMP,"",              0,        32'h0, 32'h8000_0000, 32'd9, 0);
    add(K_IDLE,"",              0,        32'd4, 0, 0, 0);
    add(K_RD,  "edge_status",   STATUS,   0, 0, 0, 32'h200);
    add(K_RD,  "edge_peak_hi",  PEAK_HI,  0, 0, 0, 32'h8000_0000);
    add(K_RD,  "edge_peak_lo",  PEAK_LO,  0, 0, 0, 32'h0);
    add(K_RD,  "edge_peak_cnt", PEAK_CNT, 0, 0, 0, 32'd9);

    idle(3);
    @(negedge clk);
    rst = 1'b1;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_WR:   wr(tbl[i].off, tbl[i].a);
        K_RD:   rd_chk(tbl[i].name, tbl[i].off, tbl[i].exp);
        K_DUMP: dump(tbl[i].a, tbl[i].b, tbl[i].c);
        K_IDLE: idle(int'(tbl[i].a));
        K_IRQ:  irq_chk(tbl[i].name, tbl[i].exp[0]);
        default: ;
      endcase
    end

    // Overflow: 18 dumps into a 16-deep FIFO with zero threshold.
    wr(THR_LO, 32'h0);
    wr(THR_HI, 32'h0);
    wr(CTRL, 32'h7);
    for (int i = 0; i < 18; i++) dump(32'h1000 + i, 32'h0, 32'd100 + i);
    idle(4);
    rd_chk("ovf_status",   STATUS,   32'hC10);
    rd_chk("ovf_drops",    DROPS,    32'd2);
    rd_chk("ovf_head_cnt", HEAD_CNT, 32'd100);
    rd_chk("ovf_head_lo",  HEAD_LO,  32'h1000);
    rd_chk("ovf_peak_cnt", PEAK_CNT, 32'd117);
    irq_chk("ovf_irq", 1'b1);

    // Full FIFO: push reaches S3 in the same cycle as the HEAD_HI pop.
    dump(32'h2000, 32'h0, 32'd200);
    idle(1);
    rd_chk("simul_pop_hi", HEAD_HI, 32'h0);
    idle(3);
    rd_chk("simul_status",   STATUS,   32'hC10);
    rd_chk("simul_drops",    DROPS,    32'd2);
    rd_chk("simul_head_cnt", HEAD_CNT, 32'd101);

    // Asynchronous reset with entries queued.
    wr(CTRL, 32'h7);
    for (int i = 0; i < 3; i++) dump(32'h10 + i, 32'h0, 32'd1 + i);
    idle(4);
    rd_chk("pre_rst_status", STATUS, 32'h003);
    irq_chk("pre_rst_irq", 1'b1);
    @(negedge clk);
    addr = BASE + 32'h4; read = 1'b1;
    rst = 1'b0;
    #1;
    chk("in_rst_rdata", Rdata, 32'h0);
    chk("in_rst_irq", {31'd0, Irq}, 32'h0);
    idle(2);
    @(negedge clk);
    read = 1'b0;
    rst = 1'b1;
    rd_chk("post_rst_status", STATUS,  32'h200);
    rd_chk("post_rst_head",   HEAD_HI, 32'h0);
    rd_chk("post_rst_ctrl",   CTRL,    32'h0);
    rd_chk("post_rst_peak",   PEAK_LO, 32'h0);
    irq_chk("post_rst_irq", 1'b0);

    // CLEAR lands while a dump is mid-pipeline.
    wr(CTRL, 32'h3);
    dump(32'h50, 32'h0, 32'd1);
    dump(32'h60, 32'h0, 32'd2);
    idle(4);
    irq_chk("clr_pre_irq", 1'b1);
    dump(32'h7000, 32'h0, 32'd3);
    wr(CTRL, 32'h7);
    irq_chk("clr_irq_hold", 1'b1);
    idle(1);
    irq_chk("clr_irq_fall", 1'b0);
    idle(3);
    rd_chk("clr_status",   STATUS,   32'h200);
    rd_chk("clr_peak_lo",  PEAK_LO,  32'h0);
    rd_chk("clr_peak_cnt", PEAK_CNT, 32'h0);
    rd_chk("clr_ctrl",     CTRL,     32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
